// File: rtl/rr_mux_arbiter_8x16.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter_8x16
//
// Round-robin arbiter and sequencer in front of one shared 8-way selection
// datapath. One requester at a time owns the datapath for at most BURST_LEN
// consecutive cycles. While it owns it, its word is registered onto O with a
// valid flag. On release the arbiter re-decides in the same edge, so there is
// no idle bubble between consecutive owners.
//
// Parameters
//   WIDTH      data width of each source word and of O
//   BURST_LEN  maximum consecutive grant cycles per owner (1..15)
//
// Ports
//   clk      in   rising-edge system clock
//   reset    in   asynchronous, active-high reset
//   req      in   [7:0] request lines; req[i] belongs to source I(i+1)
//   I1..I8   in   [WIDTH-1:0] source words (I1 is index 0)
//   grant    out  [7:0] one-hot grant, registered; zero when idle
//   sel      out  [2:0] binary index of the granted source; zero when idle
//   busy     out  high while a source owns the datapath
//   O        out  [WIDTH-1:0] registered output word
//   valid    out  high when O holds a word captured from a granted source
// ---------------------------------------------------------------------------
module rr_mux_arbiter_8x16 #(
    parameter int WIDTH     = 16,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       req,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic [WIDTH-1:0] I4,
    input  logic [WIDTH-1:0] I5,
    input  logic [WIDTH-1:0] I6,
    input  logic [WIDTH-1:0] I7,
    input  logic [WIDTH-1:0] I8,
    output logic [7:0]       grant,
    output logic [2:0]       sel,
    output logic             busy,
    output logic [WIDTH-1:0] O,
    output logic             valid
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Terminal value of the burst counter: the owner is released on the
    // edge where the counter already shows its last allowed cycle.
    localparam logic [3:0] CNT_LAST = 4'(BURST_LEN - 1);

    // Round-robin pick. Returns {found, index}: the first requesting index
    // when scanning start, start+1, ... start+7 (the 3-bit add wraps mod 8).
    function automatic logic [3:0] rr_pick(input logic [2:0] start,
                                           input logic [7:0] r);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            idx = start + 3'(k);
            if (!res[3] && r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Binary index to one-hot grant vector.
    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

    logic [0:0]       state_q, state_d;
    logic [2:0]       ptr_q,   ptr_d;
    logic [3:0]       cnt_q,   cnt_d;
    logic [7:0]       grant_q, grant_d;
    logic [2:0]       sel_q,   sel_d;
    logic             busy_q,  busy_d;
    logic [WIDTH-1:0] o_q,     o_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] mux_s;
    logic             release_s;
    logic [2:0]       ptr_rel_s;
    logic [3:0]       pick_idle_s;
    logic [3:0]       pick_rel_s;

    // Shared 8-way datapath: word of the currently granted source.
    always_comb begin
        mux_s = {WIDTH{1'b0}};
        case (sel_q)
            3'd0:    mux_s = I1;
            3'd1:    mux_s = I2;
            3'd2:    mux_s = I3;
            3'd3:    mux_s = I4;
            3'd4:    mux_s = I5;
            3'd5:    mux_s = I6;
            3'd6:    mux_s = I7;
            3'd7:    mux_s = I8;
            default: mux_s = {WIDTH{1'b0}};
        endcase
    end

    // Arbitration terms. On release the pointer moves past the current
    // owner, so the owner itself is still eligible but at lowest priority.
    always_comb begin
        release_s   = (req[sel_q] == 1'b0) || (cnt_q == CNT_LAST);
        ptr_rel_s   = sel_q + 3'd1;
        pick_idle_s = rr_pick(ptr_q, req);
        pick_rel_s  = rr_pick(ptr_rel_s, req);
    end

    // Next-state logic for the IDLE/GRANT sequencer and its datapath.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        o_d     = o_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_idle_s[3]) begin
                    grant_d = onehot8(pick_idle_s[2:0]);
                    sel_d   = pick_idle_s[2:0];
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // Capture happens on every owned edge, including the one on
                // which the owner drops its request.
                o_d     = mux_s;
                valid_d = 1'b1;
                if (release_s) begin
                    ptr_d = ptr_rel_s;
                    if (pick_rel_s[3]) begin
                        grant_d = onehot8(pick_rel_s[2:0]);
                        sel_d   = pick_rel_s[2:0];
                        cnt_d   = 4'd0;
                        state_d = ST_GRANT;
                    end else begin
                        grant_d = 8'h00;
                        sel_d   = 3'd0;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 8'h00;
                sel_d   = 3'd0;
                busy_d  = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 3'd0;
            cnt_q   <= 4'd0;
            grant_q <= 8'h00;
            sel_q   <= 3'd0;
            busy_q  <= 1'b0;
            o_q     <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            o_q     <= o_d;
            valid_q <= valid_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = busy_q;
    assign O     = o_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter_8x16.sv
// Testbench for rr_mux_arbiter_8x16: two instances (BURST_LEN 4 and 2) share
// the same stimulus. A behavioural reference model produces the expected
// outputs, pushed into per-instance queues at stimulus time and popped when
// the registered outputs are sampled. Directed checks cover the scenarios
// with hand-derived constants.
module tb_rr_mux_arbiter_8x16;

    typedef struct {
        logic [7:0]  grant;
        logic [2:0]  sel;
        logic        busy;
        logic [15:0] o;
        logic        valid;
    } exp_t;

    logic        clk;
    logic        reset_r;
    logic [7:0]  req_r;
    logic [15:0] data_r [8];

    logic [7:0]  grant4, grant2;
    logic [2:0]  sel4, sel2;
    logic        busy4, busy2;
    logic [15:0] o4, o2;
    logic        valid4, valid2;

    int n_checks;
    int n_pass;
    string phase_s;

    exp_t q4[$];
    exp_t q2[$];

    // Reference model state, index 0 = BURST_LEN 4, index 1 = BURST_LEN 2
    int          bl      [2];
    int          m_state [2];
    int          m_ptr   [2];
    int          m_cnt   [2];
    int          m_sel   [2];
    logic [7:0]  m_grant [2];
    logic        m_busy  [2];
    logic [15:0] m_o     [2];
    logic        m_valid [2];

    rr_mux_arbiter_8x16 #(.WIDTH(16), .BURST_LEN(4)) dut4 (
        .clk(clk), .reset(reset_r), .req(req_r),
        .I1(data_r[0]), .I2(data_r[1]), .I3(data_r[2]), .I4(data_r[3]),
        .I5(data_r[4]), .I6(data_r[5]), .I7(data_r[6]), .I8(data_r[7]),
        .grant(grant4), .sel(sel4), .busy(busy4), .O(o4), .valid(valid4)
    );

    rr_mux_arbiter_8x16 #(.WIDTH(16), .BURST_LEN(2)) dut2 (
        .clk(clk), .reset(reset_r), .req(req_r),
        .I1(data_r[0]), .I2(data_r[1]), .I3(data_r[2]), .I4(data_r[3]),
        .I5(data_r[4]), .I6(data_r[5]), .I7(data_r[6]), .I8(data_r[7]),
        .grant(grant2), .sel(sel2), .busy(busy2), .O(o2), .valid(valid2)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int rr_pick(input int start, input logic [7:0] r);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset(input int k);
        m_state[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0; m_sel[k] = 0;
        m_grant[k] = 8'h00; m_busy[k] = 1'b0; m_o[k] = 16'h0000; m_valid[k] = 1'b0;
    endtask

    // One rising edge of the reference arbiter with the current inputs.
    task automatic model_edge(input int k);
        int w;
        int g;
        if (m_state[k] == 0) begin
            m_valid[k] = 1'b0;
            w = rr_pick(m_ptr[k], req_r);
            if (w >= 0) begin
                m_sel[k] = w; m_grant[k] = 8'h01 << w; m_cnt[k] = 0;
                m_busy[k] = 1'b1; m_state[k] = 1;
            end
        end else begin
            g = m_sel[k];
            m_o[k] = data_r[g];
            m_valid[k] = 1'b1;
            if (!req_r[g] || m_cnt[k] == bl[k] - 1) begin
                m_ptr[k] = (g + 1) % 8;
                w = rr_pick(m_ptr[k], req_r);
                if (w >= 0) begin
                    m_sel[k] = w; m_grant[k] = 8'h01 << w; m_cnt[k] = 0;
                end else begin
                    m_grant[k] = 8'h00; m_sel[k] = 0; m_busy[k] = 1'b0; m_state[k] = 0;
                end
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
            end
        end
    endtask

    function automatic exp_t model_out(input int k);
        exp_t e;
        e.grant = m_grant[k]; e.sel = 3'(m_sel[k]); e.busy = m_busy[k];
        e.o = m_o[k]; e.valid = m_valid[k];
        return e;
    endfunction

    task automatic push_expected();
        q4.push_back(model_out(0));
        q2.push_back(model_out(1));
    endtask

    task automatic compare_inst(input string name, input exp_t e,
                                input logic [7:0] g, input logic [2:0] s,
                                input logic b, input logic [15:0] o,
                                input logic v);
        check_val($sformatf("%s/%s.grant", phase_s, name), 32'(g), 32'(e.grant));
        check_val($sformatf("%s/%s.sel",   phase_s, name), 32'(s), 32'(e.sel));
        check_val($sformatf("%s/%s.busy",  phase_s, name), 32'(b), 32'(e.busy));
        check_val($sformatf("%s/%s.O",     phase_s, name), 32'(o), 32'(e.o));
        check_val($sformatf("%s/%s.valid", phase_s, name), 32'(v), 32'(e.valid));
    endtask

    task automatic pop_compare();
        exp_t e;
        if (q4.size() == 0 || q2.size() == 0) begin
            check_val({phase_s, "/queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = q4.pop_front();
            compare_inst("b4", e, grant4, sel4, busy4, o4, valid4);
            e = q2.pop_front();
            compare_inst("b2", e, grant2, sel2, busy2, o2, valid2);
        end
    endtask

    // Called at a falling edge with inputs already set; returns at the next
    // falling edge after comparing the outputs of the rising edge between.
    task automatic cycle();
        for (int k = 0; k < 2; k++) begin
            if (reset_r) model_reset(k);
            else model_edge(k);
        end
        push_expected();
        @(posedge clk);
        #1;
        pop_compare();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        bl[0] = 4;
        bl[1] = 2;
        reset_r = 1'b1;
        req_r   = 8'h00;
        for (int i = 0; i < 8; i++) data_r[i] = 16'h0000;
        model_reset(0);
        model_reset(1);

        // Reset state
        phase_s = "reset";
        @(negedge clk);
        cycle();
        cycle();
        reset_r = 1'b0;

        // Single requester: source index 2 holds req across burst expiry
        phase_s = "single";
        for (int i = 0; i < 8; i++) data_r[i] = 16'($urandom);
        data_r[2] = 16'hA5A5;
        req_r = 8'h04;
        cycle();
        check_val("single.first_grant", 32'(grant4), 32'h04);
        check_val("single.first_sel",   32'(sel4),   32'd2);
        check_val("single.first_valid", 32'(valid4), 32'd0);
        cycle();
        check_val("single.valid_lag", 32'(valid4), 32'd1);
        check_val("single.O",         32'(o4),      32'hA5A5);
        for (int c = 0; c < 10; c++) begin
            cycle();
            check_val("single.grant_held", 32'(grant4), 32'h04);
        end

        // Go idle: the sole requester drops
        phase_s = "idle";
        req_r = 8'h00;
        cycle();
        check_val("idle.grant", 32'(grant4), 32'h00);
        check_val("idle.busy",  32'(busy4),  32'd0);
        check_val("idle.last_valid", 32'(valid4), 32'd1);
        check_val("idle.last_O",     32'(o4),     32'hA5A5);
        cycle();
        check_val("idle.valid_low", 32'(valid4), 32'd0);
        check_val("idle.O_hold",    32'(o4),     32'hA5A5);

        // Mid-burst asynchronous reset
        phase_s = "async_rst";
        req_r = 8'hFF;
        cycle();
        cycle();
        cycle();
        #2;
        reset_r = 1'b1;
        model_reset(0);
        model_reset(1);
        push_expected();
        #1;
        pop_compare();
        check_val("async_rst.busy4_now", 32'(busy4), 32'd0);
        @(negedge clk);
        req_r = 8'h00;
        cycle();
        reset_r = 1'b0;
        for (int c = 0; c < 3; c++) cycle();

        // Full contention from reset; BURST_LEN 2 gives 0,0,1,1,...,7,7,0,0
        phase_s = "contend";
        for (int i = 0; i < 8; i++) data_r[i] = 16'h1000 + 16'(i);
        req_r = 8'hFF;
        for (int c = 1; c <= 18; c++) begin
            cycle();
            check_val($sformatf("contend.sel2_c%0d", c), 32'(sel2), 32'(((c - 1) / 2) % 8));
            if (c >= 2) begin
                check_val($sformatf("contend.O2_c%0d", c), 32'(o2),
                          32'h1000 + 32'(((c - 2) / 2) % 8));
            end
        end

        // Early drop from source 0 and wrap from 7 back to 0
        phase_s = "early_drop";
        reset_r = 1'b1;
        cycle();
        reset_r = 1'b0;
        req_r = 8'h81;
        cycle();
        check_val("early_drop.grant_src0", 32'(grant4), 32'h01);
        req_r = 8'h80;
        cycle();
        check_val("early_drop.no_bubble", 32'(grant4), 32'h80);
        check_val("early_drop.busy",      32'(busy4),  32'd1);
        req_r = 8'h81;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check_val("early_drop.src7_burst", 32'(grant4), 32'h80);
        end
        cycle();
        check_val("wrap.grant", 32'(grant4), 32'h01);
        check_val("wrap.sel",   32'(sel4),   32'd0);
        cycle();
        cycle();

        // Random traffic
        phase_s = "random";
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < 8; i++) data_r[i] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) req_r = 8'h00;
            else req_r = 8'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter_8x16.md
Name: rr_mux_arbiter_8x16

Overview:
- Round-robin arbiter and sequencer that shares one 8-way, 16-bit selection datapath between eight requesters.
- Picks one requester at a time and holds the grant for a bounded burst. Drives the 3-bit select in binary and the one-hot grant vector.
- Registers the selected 16-bit word with a valid flag for the downstream consumer.
- Sits between the requesting sources and the shared output bus.

Parameters:
- WIDTH, 16, data width of each input word and of O.
- BURST_LEN, 4, maximum consecutive cycles one requester may hold the grant. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  8  request lines; req[i] belongs to source I(i+1).
- I1..I8  input  WIDTH each  source data words; I1 is index 0, I8 is index 7.
- grant  output  8  one-hot grant, registered; all-zero when idle.
- sel  output  3  binary index of the granted source, registered; 0 when idle.
- busy  output  1  high while in GRANT state.
- O  output  WIDTH  registered output word.
- valid  output  1  high when O holds a word captured from a granted source.

Behaviour:
- Reset (async, active-high): state=IDLE, ptr=0, cnt=0, grant=0, sel=0, busy=0, O=0, valid=0.
  - Outputs reach these values immediately on reset assertion, without waiting for a clock edge.
  - Reset asserted mid-burst aborts the burst. After release the arbiter restarts from ptr=0.
- Internal state:
  - ptr: 3-bit round-robin pointer, the highest-priority index for the next decision.
  - cnt: 4-bit burst counter.
  - state: IDLE or GRANT.
- Arbitration function pick(ptr, req): the first index j scanning ptr, ptr+1, ..., ptr+7 (mod 8) with req[j]=1. No result if req=0.
- IDLE:
  - If req!=0: grant<=onehot(pick), sel<=pick, cnt<=0, busy<=1, state<=GRANT.
  - Otherwise stay in IDLE.
  - In both cases valid<=0 and O holds its last value.
- GRANT, with g = sel. Every cycle: O<=I(g+1), valid<=1. Valid therefore lags the first grant cycle by exactly one cycle.
- Release condition: req[g]==0 OR cnt==BURST_LEN-1.
  - Not release: cnt<=cnt+1; grant and sel unchanged.
  - Release: ptr<=(g+1) mod 8 (wraps 7->0), then re-arbitrate in the same edge using the new ptr and the current req.
    - If a winner exists: grant/sel<=winner, cnt<=0, stay in GRANT. No idle bubble between owners.
    - If no winner: grant<=0, sel<=0, busy<=0, state<=IDLE.
- Re-arbitration includes g itself, at lowest priority.
  - A sole requester whose burst expires is re-granted back-to-back with cnt reset.
  - ptr still advances past it.
- On a release caused by req[g] dropping, the capture still happens that edge: O<=I(g+1), valid<=1 for that final edge.
- BURST_LEN=1: re-arbitration every cycle, giving strict per-cycle round-robin.
- No more than one grant bit is ever set. grant==0 if and only if busy==0.
- Inputs I1..I8 need not be stable outside the granted index.
- Requests are level-sensitive. Deasserting a non-granted req has no effect until the next decision.

Test Plan:
- Reset check: assert reset mid-burst with req=8'hFF, asynchronously between edges -> grant=0, sel=0, busy=0, valid=0, O=0 immediately. After release with req=8'h00, outputs stay idle.
- Single requester, BURST_LEN=4:
  - Stimulus: req=8'h04 held; I3=16'hA5A5.
  - Response: grant=8'h04, sel=2 one cycle after req; valid=1 and O=16'hA5A5 the following cycle.
  - The grant stays continuous across burst expiry, re-granted with cnt reset. Internal ptr becomes 3 after 4 cycles.
- Full contention, BURST_LEN=2, req=8'hFF from reset -> grant order 0,0,1,1,2,2,...,7,7,0,0. Each I(i+1)=16'h1000+i appears on O one cycle after its grant cycles.
- Early drop, BURST_LEN=4, req=8'h81 (sources 0 and 7):
  - Source 0 drops req after 1 grant cycle.
  - Response: grant moves directly to 8'h80 on the next edge with no idle cycle; ptr=1.
  - The next grant to source 0 comes only after source 7's burst.
- Wrap-around: grant index 7 with ptr at 7, burst expires, req=8'h81 -> next grant=8'h01, sel=0, since ptr wrapped to 0.
- Go idle: sole requester drops req -> the next edge gives grant=0, busy=0. valid=1 for one more cycle carrying the final word, then valid=0 while O holds that word.
